// File: rtl/yl3_pkg.sv
// Shared definitions for the YL-3 display arbiter: page width, blank page,
// frame sequencer states and a one-hot decode helper.
package yl3_pkg;

  localparam int unsigned PAGE_W = 64;

  // Eight ASCII spaces: every digit dark.
  localparam logic [PAGE_W-1:0] DEF_BLANK_PAGE = 64'h2020_2020_2020_2020;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_LOAD = 2'd2,
    ST_BUSY = 2'd3
  } state_e;

  function automatic int unsigned oh2idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/yl3_display_arbiter_if.sv
// Requester and display-driver signals of the arbiter. The master modport is the
// arbiter's view; the slave modport is the application/driver side.
interface yl3_display_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import yl3_pkg::*;

  logic [NREQ-1:0]        REQ_VALID;
  logic [NREQ-1:0]        REQ_URGENT;
  logic [PAGE_W*NREQ-1:0] REQ_DATA;
  logic [NREQ-1:0]        GRANT;
  logic                   DISP_READY;
  logic                   DISP_LOAD;
  logic [PAGE_W-1:0]      DISP_DATA;
  logic                   FRAME_DONE;
  logic                   TIMEOUT_ERR;

  modport master (
    input  REQ_VALID, REQ_URGENT, REQ_DATA, DISP_READY,
    output GRANT, DISP_LOAD, DISP_DATA, FRAME_DONE, TIMEOUT_ERR
  );

  modport slave (
    output REQ_VALID, REQ_URGENT, REQ_DATA, DISP_READY,
    input  GRANT, DISP_LOAD, DISP_DATA, FRAME_DONE, TIMEOUT_ERR
  );

endinterface

// File: rtl/yl3_rr_pick.sv
// Combinational owner picker: lowest urgent index, else keep the current owner,
// else round-robin starting just after the owner pointer (owner itself last).
module yl3_rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [NREQ-1:0]         urgent,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    keep,
  output logic [NREQ-1:0]         grant,
  output logic                    none
);

  logic [NREQ-1:0] hot;
  logic            found;

  assign hot  = valid & urgent;
  assign none = ~|valid;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (|hot) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (hot[j] && !found) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end else if (keep) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (32'(ptr) == j) grant[j] = 1'b1;
      end
    end else begin
      // Indices above the pointer first, then wrap to 0..ptr.
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (valid[j] && (j > 32'(ptr)) && !found) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (valid[j] && (j <= 32'(ptr)) && !found) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/yl3_display_arbiter.sv
// Shares one YL-3 display driver between NREQ requesters, picking an owner per
// frame and running the LOAD/READY handshake back-to-back.
module yl3_display_arbiter #(
  parameter int unsigned              NREQ           = 4,
  parameter int unsigned              DWELL_CYCLES   = 50000000,
  parameter int unsigned              TIMEOUT_CYCLES = 1024,
  parameter logic [yl3_pkg::PAGE_W-1:0] BLANK_PAGE   = yl3_pkg::DEF_BLANK_PAGE
) (
  input logic                   CLK,
  input logic                   nRST,
  yl3_display_arbiter_if.master bus
);
  import yl3_pkg::*;

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              ready_q;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              load_q, load_d;
  logic [PAGE_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;

  logic [NREQ-1:0]   pick_grant;
  logic              pick_none;
  logic [PAGE_W-1:0] pick_page;
  logic              keep;

  // Hold the owner only while it is still asking and its dwell has not run out.
  assign keep = (|(grant_q & bus.REQ_VALID)) && (dwell_q != DWELL_MAX);

  yl3_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .valid  (bus.REQ_VALID),
    .urgent (bus.REQ_URGENT),
    .ptr    (ptr_q),
    .keep   (keep),
    .grant  (pick_grant),
    .none   (pick_none)
  );

  always_comb begin
    pick_page = BLANK_PAGE;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) pick_page = bus.REQ_DATA[i*PAGE_W +: PAGE_W];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    load_d  = load_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ptr_d   = ptr_q;
    tmo_d   = '0;
    dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (ready_q) state_d = ST_ARB;
      end
      ST_ARB: begin
        grant_d = pick_grant;
        data_d  = pick_page;
        load_d  = 1'b1;
        if (!pick_none) ptr_d = PTR_W'(oh2idx(8'(pick_grant)));
        if (pick_grant != grant_q) dwell_d = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Acceptance wins over a timeout expiring in the same cycle.
        if (!ready_q) begin
          load_d  = 1'b0;
          state_d = ST_BUSY;
        end else if (tmo_q == TO_MAX) begin
          load_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (ready_q) begin
          done_d  = 1'b1;
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      grant_q <= '0;
      load_q  <= 1'b0;
      data_q  <= BLANK_PAGE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= PTR_W'(NREQ - 1);
      dwell_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= bus.DISP_READY;
      grant_q <= grant_d;
      load_q  <= load_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.GRANT       = grant_q;
  assign bus.DISP_LOAD   = load_q;
  assign bus.DISP_DATA   = data_q;
  assign bus.FRAME_DONE  = done_q;
  assign bus.TIMEOUT_ERR = err_q;

endmodule

// File: doc/yl3_display_arbiter.md
Name: yl3_display_arbiter

Overview:
- Shares one 8-digit YL-3 display driver between NREQ independent requesters (clock, sensor readout, status message, ...).
- Picks an owner per frame: urgent requests first, otherwise round-robin with a minimum dwell time per owner.
- Sequences the driver's LOAD/READY handshake continuously, so the multiplexed display is always re-driven.
- Sits between application logic and yl3_interface; owns its DATA/LOAD inputs and READY output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWELL_CYCLES, 50000000, minimum CLK cycles an owner keeps the display before rotation (1 s at 50 MHz).
- TIMEOUT_CYCLES, 1024, max cycles DISP_LOAD may stay high without DISP_READY falling.
- BLANK_PAGE, 64'h2020_2020_2020_2020, page sent when nobody requests (8 spaces = all segments off).

Ports:
- CLK  in  1  system clock. Reset is nRST, synchronous, active-low; clock is CLK.
- nRST  in  1  synchronous active-low reset.
- REQ_VALID  in  NREQ  requester i wants the display.
- REQ_URGENT  in  NREQ  requester i requests preemption (qualified by REQ_VALID[i]).
- REQ_DATA  in  64*NREQ  page of requester i at [64*i+63:64*i], byte 63:56 = leftmost digit, ASCII.
- GRANT  out  NREQ  one-hot current owner; all-zero when showing BLANK_PAGE.
- DISP_READY  in  1  driver ready for a new page.
- DISP_LOAD  out  1  load strobe to driver (level, held until accepted).
- DISP_DATA  out  64  page to driver.
- FRAME_DONE  out  1  one-cycle pulse per completed frame.
- TIMEOUT_ERR  out  1  sticky: driver failed to accept a load.

Behaviour:
- All outputs registered. Reset values: GRANT=0, DISP_LOAD=0, DISP_DATA=BLANK_PAGE, FRAME_DONE=0, TIMEOUT_ERR=0. Internal reset: state ST_IDLE, owner pointer=NREQ-1 (first rotation starts at index 0), dwell=0, timeout count=0.
- States:
  - ST_IDLE: wait for DISP_READY=1, then go to ST_ARB.
  - ST_ARB: one cycle. Choose the owner, register GRANT and DISP_DATA, set DISP_LOAD=1, go to ST_LOAD.
  - ST_LOAD: hold DISP_LOAD=1 and DISP_DATA. If DISP_READY=0 is sampled, set DISP_LOAD=0 and go to ST_BUSY. If the timeout count reaches TIMEOUT_CYCLES-1, set DISP_LOAD=0 and TIMEOUT_ERR=1, and go to ST_IDLE.
  - ST_BUSY: when DISP_READY=1 is sampled, pulse FRAME_DONE for one cycle and go to ST_ARB.
- Latency: DISP_READY=1 at reset release gives DISP_LOAD=1 on the 3rd rising edge after nRST is first sampled high.
- Arbitration runs in ST_ARB only. Ownership never changes mid-frame. Priority order:
  1. Any REQ_VALID&REQ_URGENT: lowest such index wins, dwell ignored.
  2. Current owner still valid and dwell not expired: keep owner.
  3. Otherwise round-robin: first valid index after the owner pointer, wrapping NREQ-1 to 0. The current owner is eligible last.
  4. No valid requester: GRANT=0, DISP_DATA=BLANK_PAGE, owner pointer unchanged.
- Dwell counter:
  - Cleared on any owner change, including to or from blank.
  - Otherwise increments every cycle, saturating at DWELL_CYCLES-1; "expired" means it equals DWELL_CYCLES-1.
  - Width is clog2(DWELL_CYCLES).
- Owner deasserting REQ_VALID loses the grant at the next ST_ARB regardless of dwell.
- REQ_DATA is sampled only in ST_ARB. Changes during a frame appear on the next frame. Since frames repeat back-to-back, a live owner's updates show within one frame time.
- Timeout count clears on entry to ST_LOAD and is 0 outside ST_LOAD. TIMEOUT_ERR is cleared only by reset; arbitration keeps running after an error.
- Simultaneous events:
  - DISP_READY falling in the same cycle the timeout expires counts as acceptance (no error).
  - A new urgent request arriving during ST_LOAD or ST_BUSY waits for the next ST_ARB.
- Reset mid-frame: all state and outputs return to reset values at the same edge; the driver shares nRST.

Decomposition:
- Shared package yl3_pkg:
  - state encoding: ST_IDLE, ST_ARB, ST_LOAD, ST_BUSY (2 bits);
  - BLANK_PAGE constant;
  - PAGE_W=64;
  - helper function for one-hot to index.
- Sub-module yl3_rr_pick: combinational round-robin/priority picker. Inputs: valid, urgent, owner pointer, keep flag. Outputs: one-hot grant and a none-valid flag.

Test Plan:
- Blank path: no REQ_VALID, driver model READY drops 2 cycles after LOAD and returns 20 cycles later -> DISP_DATA=2020202020202020, GRANT=0000, FRAME_DONE pulses every frame.
- Dwell and rotation: DWELL_CYCLES=100, REQ_VALID=0101 -> GRANT=0001 for at least 100 cycles, then 0100, then 0001; changes occur only in ST_ARB.
- Urgent preemption: owner 0 at dwell 10, assert REQ_URGENT[3]=1 with REQ_VALID[3]=1 -> GRANT=1000 at the next frame boundary, dwell reset to 0.
- Owner drop: owner 2 deasserts REQ_VALID mid-frame, REQ_VALID=0010 -> current frame completes with owner 2's data; next frame GRANT=0010.
- Timeout: driver holds READY=1 and ignores LOAD -> DISP_LOAD low after TIMEOUT_CYCLES cycles, TIMEOUT_ERR=1 and stays 1 while frames resume once the driver recovers.
- Reset mid-frame: nRST=0 during ST_BUSY -> next edge DISP_LOAD=0, GRANT=0, DISP_DATA=BLANK_PAGE; the first grant after release goes to the lowest valid index.
